// File: rtl/eeprom_ctrl_pkg.sv
// Shared types and defaults for the parallel EEPROM sequencing controller.
// Imported by the controller, its timer, the host interface and the bench.
package eeprom_ctrl_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam int DEF_T_SETUP = 1;
    localparam int DEF_T_PULSE = 2;
    localparam int DEF_T_WC    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RD_STROBE,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_POLL,
        ST_RESP
    } state_e;

    // A phase of N cycles needs the timer loaded with N-1, since done is seen on the last cycle.
    function automatic logic [CNT_W-1:0] cycles_to_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/eeprom_ctrl_if.sv
// Host-side request/response handshake for the EEPROM controller.
interface eeprom_ctrl_if;
    import eeprom_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/eeprom_timer.sv
// Loadable down-counter with a done flag; reused for setup, strobe and poll phases.
module eeprom_timer
    import eeprom_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/eeprom_ctrl.sv
// Sequencer for an AT28C256-style EEPROM: timed read/write strobes plus I/O7 data polling.
// Pin outputs are registered from the next state so CE/OE/WE only move on state edges.
module eeprom_ctrl
    import eeprom_ctrl_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_WC    = DEF_T_WC
) (
    input  logic              clk,
    input  logic              rst_n,
    eeprom_ctrl_if.slave      host,
    output logic [ADDR_W-1:0] rom_a,
    output logic              rom_ce,
    output logic              rom_oe,
    output logic              rom_we,
    inout  wire  [DATA_W-1:0] rom_io
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              is_wr_q, is_wr_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              ce_q, ce_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              io_oe_q, io_oe_d;

    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_done;
    logic [CNT_W-1:0]  tmr_val;

    eeprom_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        is_wr_d  = is_wr_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (host.req_valid) begin
                    addr_d   = host.req_addr;
                    wdata_d  = host.req_wdata;
                    is_wr_d  = host.req_we;
                    tmr_load = 1'b1;
                    tmr_val  = cycles_to_load(T_SETUP);
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = cycles_to_load(T_PULSE);
                    state_d  = is_wr_q ? ST_WR_STROBE : ST_RD_STROBE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RD_STROBE: begin
                if (tmr_done) begin
                    rdata_d = rom_io;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WR_STROBE: begin
                if (tmr_done) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                tmr_load = 1'b1;
                tmr_val  = cycles_to_load(T_WC);
                state_d  = ST_POLL;
            end
            // The part returns the complement of the written I/O7 until its write cycle ends.
            ST_POLL: begin
                if (rom_io[DATA_W-1] == wdata_q[DATA_W-1]) begin
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmr_done) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == ST_RESP);
        ce_d        = !(state_d inside {ST_SETUP, ST_RD_STROBE, ST_WR_STROBE, ST_WR_HOLD, ST_POLL});
        oe_d        = !(state_d inside {ST_RD_STROBE, ST_POLL});
        we_d        = (state_d != ST_WR_STROBE);
        io_oe_d     = ((state_d == ST_SETUP) && is_wr_d) ||
                      (state_d == ST_WR_STROBE) || (state_d == ST_WR_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            is_wr_q     <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            io_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            is_wr_q     <= is_wr_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            io_oe_q     <= io_oe_d;
        end
    end

    assign host.req_ready = (state_q == ST_IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rdata_q;
    assign host.rsp_err   = err_q;

    assign rom_a  = addr_q;
    assign rom_ce = ce_q;
    assign rom_oe = oe_q;
    assign rom_we = we_q;
    assign rom_io = io_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Directed bench for eeprom_ctrl: default-timing instance plus a stretched-timing instance,
// each against a small behavioural EEPROM that can delay its I/O7 polling answer.
module tb_eeprom_ctrl;
    import eeprom_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;

    eeprom_ctrl_if hst ();
    eeprom_ctrl_if hst2 ();

    logic [14:0] rom_a, rom_a2;
    logic        rom_ce, rom_oe, rom_we;
    logic        rom_ce2, rom_oe2, rom_we2;
    wire  [7:0]  rom_io, rom_io2;

    int n_checks = 0;
    int n_errors = 0;

    eeprom_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .host   (hst),
        .rom_a  (rom_a),
        .rom_ce (rom_ce),
        .rom_oe (rom_oe),
        .rom_we (rom_we),
        .rom_io (rom_io)
    );

    eeprom_ctrl #(.T_SETUP(3), .T_PULSE(4), .T_WC(16)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .host   (hst2),
        .rom_a  (rom_a2),
        .rom_ce (rom_ce2),
        .rom_oe (rom_oe2),
        .rom_we (rom_we2),
        .rom_io (rom_io2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EEPROM model: a write commits on the cycle after WE rises, then I/O7 reads inverted
    // for poll_delay OE-low cycles.
    logic [7:0] mem [0:32767];
    int         busy = 0;
    int         poll_delay = 0;
    logic       we_prev = 1'b1;
    logic [7:0] stub_data;

    initial begin
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
    end

    assign stub_data = (busy > 0) ? {~mem[rom_a][7], mem[rom_a][6:0]} : mem[rom_a];
    assign rom_io    = (!rom_ce && !rom_oe && rom_we) ? stub_data : 8'hzz;

    always @(posedge clk) begin
        we_prev <= rom_we;
        if (!we_prev && rom_we && !rom_ce) begin
            mem[rom_a] <= rom_io;
            busy       <= poll_delay;
        end else if (!rom_ce && !rom_oe && busy > 0) begin
            busy <= busy - 1;
        end
    end

    logic [7:0] last2 = 8'h00;
    assign rom_io2 = (!rom_ce2 && !rom_oe2 && rom_we2) ? last2 : 8'hzz;
    always @(posedge clk) begin
        if (!rom_ce2 && !rom_we2) last2 <= rom_io2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge, with the first busy cycle visible.
    task automatic applyStimulus(input logic we, input logic [14:0] addr, input logic [7:0] wdata,
                                 output bit accepted);
        bit ok;
        hst.req_we    = we;
        hst.req_addr  = addr;
        hst.req_wdata = wdata;
        hst.req_valid = 1'b1;
        accepted      = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            ok = hst.req_ready;
            tick();
            if (ok) accepted = 1'b1;
        end
        hst.req_valid = 1'b0;
    endtask

    // Latency in edges from accept to rsp_valid, plus the number of OE-low cycles seen.
    task automatic waitResp(output int lat, output int oe_cycles);
        lat       = 0;
        oe_cycles = 0;
        do begin
            tick();
            lat++;
            if (!rom_oe) oe_cycles++;
        end while (!hst.rsp_valid && lat < 100);
    endtask

    initial begin
        bit         acc;
        bit         ok;
        int         lat, oe_cyc, accepts, rsps, viol, pulses;
        logic [7:0] got [3];
        int         lat2, setup_cnt, we_low;
        logic       prev_we, hold_drv, rel_ok, check_rel, rose;

        hst.req_valid  = 1'b0;
        hst.req_we     = 1'b0;
        hst.req_addr   = '0;
        hst.req_wdata  = '0;
        hst2.req_valid = 1'b0;
        hst2.req_we    = 1'b0;
        hst2.req_addr  = '0;
        hst2.req_wdata = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();

        checkOutput("rst_ready", hst.req_ready, 1);
        checkOutput("rst_strobes", {rom_ce, rom_oe, rom_we}, 3'b111);
        checkOutput("rst_addr", rom_a, 0);
        checkOutput("rst_rsp", {hst.rsp_valid, hst.rsp_err}, 2'b00);
        checkOutput("rst_rdata", hst.rsp_rdata, 0);
        checkOutput("rst_io_hiz", dut.io_oe_q, 0);

        rst_n = 1'b1;
        tick();

        applyStimulus(1'b1, 15'h1234, 8'hA5, acc);
        checkOutput("wr_accept", acc, 1);
        checkOutput("wr_setup_strobes", {rom_ce, rom_oe, rom_we}, 3'b011);
        checkOutput("wr_setup_addr", rom_a, 15'h1234);
        checkOutput("wr_setup_io", rom_io, 8'hA5);
        waitResp(lat, oe_cyc);
        checkOutput("wr_latency", lat, 5);
        checkOutput("wr_poll_cycles", oe_cyc, 1);
        checkOutput("wr_err", hst.rsp_err, 0);
        tick();
        checkOutput("wr_rsp_one_cycle", hst.rsp_valid, 0);

        applyStimulus(1'b0, 15'h1234, 8'h00, acc);
        waitResp(lat, oe_cyc);
        checkOutput("rd_latency", lat, 3);
        checkOutput("rd_oe_cycles", oe_cyc, 2);
        checkOutput("rd_data", hst.rsp_rdata, 8'hA5);
        checkOutput("rd_err", hst.rsp_err, 0);
        tick();

        poll_delay = 4;
        applyStimulus(1'b1, 15'h0100, 8'h3C, acc);
        waitResp(lat, oe_cyc);
        checkOutput("delay_latency", lat, 9);
        checkOutput("delay_poll_cycles", oe_cyc, 5);
        checkOutput("delay_err", hst.rsp_err, 0);
        poll_delay = 0;
        tick();

        hst.req_we    = 1'b0;
        hst.req_addr  = 15'h0000;
        hst.req_valid = 1'b1;
        accepts = 0;
        rsps    = 0;
        viol    = 0;
        acc     = 1'b0;
        for (int c = 0; c < 25; c++) begin
            ok = hst.req_ready && hst.req_valid;
            tick();
            if (ok) begin
                accepts++;
                acc = 1'b1;
                if (accepts == 3) hst.req_valid = 1'b0;
                else hst.req_addr = 15'(accepts);
            end
            if (acc && hst.req_ready) viol++;
            if (hst.rsp_valid) begin
                if (rsps < 3) got[rsps] = hst.rsp_rdata;
                rsps++;
                acc = 1'b0;
            end
        end
        hst.req_valid = 1'b0;
        checkOutput("b2b_accepts", accepts, 3);
        checkOutput("b2b_responses", rsps, 3);
        checkOutput("b2b_ready_while_busy", viol, 0);
        checkOutput("b2b_data0", got[0], 8'h11);
        checkOutput("b2b_data1", got[1], 8'h22);
        checkOutput("b2b_data2", got[2], 8'h33);

        poll_delay = 1000;
        applyStimulus(1'b1, 15'h0200, 8'h81, acc);
        waitResp(lat, oe_cyc);
        checkOutput("tmo_latency", lat, 20);
        checkOutput("tmo_poll_cycles", oe_cyc, 16);
        checkOutput("tmo_err", hst.rsp_err, 1);
        poll_delay = 0;
        tick();

        applyStimulus(1'b1, 15'h0300, 8'h42, acc);
        tick();
        checkOutput("rst_mid_in_strobe", rom_we, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_strobes", {rom_ce, rom_oe, rom_we}, 3'b111);
        checkOutput("rst_mid_ready", hst.req_ready, 1);
        checkOutput("rst_mid_io_hiz", dut.io_oe_q, 0);
        checkOutput("rst_mid_addr", rom_a, 0);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (hst.rsp_valid) pulses++;
        end
        checkOutput("rst_mid_no_rsp", pulses, 0);

        hst2.req_we    = 1'b1;
        hst2.req_addr  = 15'h0055;
        hst2.req_wdata = 8'h5A;
        hst2.req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            ok = hst2.req_ready;
            tick();
            if (ok) acc = 1'b1;
        end
        hst2.req_valid = 1'b0;
        checkOutput("str_accept", acc, 1);
        lat2      = 0;
        setup_cnt = 0;
        we_low    = 0;
        prev_we   = 1'b1;
        hold_drv  = 1'b0;
        rel_ok    = 1'b0;
        check_rel = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (hst2.rsp_valid) break;
            if (check_rel) rel_ok = !dut2.io_oe_q;
            rose = !prev_we && rom_we2;
            if (rose) hold_drv = dut2.io_oe_q && (rom_io2 === 8'h5A);
            check_rel = rose;
            if (!rom_ce2 && rom_we2 && we_low == 0 && rom_a2 == 15'h0055) setup_cnt++;
            if (!rom_we2) we_low++;
            prev_we = rom_we2;
            tick();
            lat2++;
        end
        checkOutput("str_setup_cycles", setup_cnt, 3);
        checkOutput("str_we_low_cycles", we_low, 4);
        checkOutput("str_hold_drive", hold_drv, 1);
        checkOutput("str_hold_release", rel_ok, 1);
        checkOutput("str_latency", lat2, 9);
        checkOutput("str_err", hst2.rsp_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
